// File: rtl/qs_srt_mstack.sv
// qs_srt_mstack: C independent LIFO stacks of N words each, sharing one
// single-port synchronous RAM. Reads (POP/PEEK) return data two cycles
// after the command; occupancy and flags are tracked per context.

// Single-port synchronous RAM: one write or one registered read per cycle.
module qs_srt_mstack_spsram #(
    parameter int W  = 32,
    parameter int D  = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [D];
    logic [W-1:0] rdata_q;

    // Storage write and registered read; read data holds between reads.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module qs_srt_mstack #(
    parameter int N = 16,
    parameter int W = 32,
    parameter int C = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_vld_r,
    input  logic [1:0]                           cmd_op_r,
    input  logic [((C > 1) ? $clog2(C) : 1)-1:0] cmd_ctx_r,
    input  logic [W-1:0]                         cmd_dat_r,
    output logic                                 cmd_err_w,
    output logic [W-1:0]                         head_r,
    output logic [((C > 1) ? $clog2(C) : 1)-1:0] head_ctx_r,
    output logic                                 head_vld_r,
    output logic [C-1:0]                         empty_r,
    output logic [C-1:0]                         full_r
);
    localparam int CW   = (C > 1) ? $clog2(C) : 1;
    localparam int IW   = $clog2(N);
    localparam int CNTW = $clog2(N + 1);
    localparam int AW   = CW + IW;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_PEEK = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    logic [CNTW-1:0] cnt_q [C];
    logic [CNTW-1:0] cnt_d [C];
    logic [C-1:0]    empty_q, full_q;

    logic [CNTW-1:0] cnt_sel, cnt_dec;
    logic            ctx_ok, sel_empty, sel_full;
    logic            err, acc;
    logic            mem_we, mem_re;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_rdata;

    logic            rd_vld_p1_q;
    logic [CW-1:0]   rd_ctx_p1_q;
    logic            head_vld_q;
    logic [W-1:0]    head_q;
    logic [CW-1:0]   head_ctx_q;

    // Command decode: acceptance check, RAM access and next occupancy.
    always_comb begin
        cnt_sel = '0;
        for (int c = 0; c < C; c++) begin
            if (cmd_ctx_r == CW'(c)) cnt_sel = cnt_q[c];
        end
        ctx_ok    = (int'(cmd_ctx_r) < C);
        sel_empty = (cnt_sel == '0);
        sel_full  = (cnt_sel == CNTW'(N));
        cnt_dec   = cnt_sel - CNTW'(1);

        err = 1'b0;
        if (!rst && cmd_vld_r) begin
            case (cmd_op_r)
                OP_PUSH: err = !ctx_ok || sel_full;
                OP_POP:  err = !ctx_ok || sel_empty;
                OP_PEEK: err = !ctx_ok || sel_empty;
                default: err = !ctx_ok;
            endcase
        end
        acc = !rst && cmd_vld_r && !err;

        mem_we   = acc && (cmd_op_r == OP_PUSH);
        mem_re   = acc && ((cmd_op_r == OP_POP) || (cmd_op_r == OP_PEEK));
        mem_addr = mem_we ? {cmd_ctx_r, cnt_sel[IW-1:0]}
                          : {cmd_ctx_r, cnt_dec[IW-1:0]};

        for (int c = 0; c < C; c++) begin
            cnt_d[c] = cnt_q[c];
            if (acc && (cmd_ctx_r == CW'(c))) begin
                case (cmd_op_r)
                    OP_PUSH: cnt_d[c] = cnt_q[c] + CNTW'(1);
                    OP_POP:  cnt_d[c] = cnt_q[c] - CNTW'(1);
                    OP_CLR:  cnt_d[c] = '0;
                    default: cnt_d[c] = cnt_q[c];
                endcase
            end
        end
    end

    assign cmd_err_w = err;

    // Occupancy counters and registered empty/full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < C; c++) cnt_q[c] <= '0;
            empty_q <= '1;
            full_q  <= '0;
        end else begin
            for (int c = 0; c < C; c++) begin
                cnt_q[c]   <= cnt_d[c];
                empty_q[c] <= (cnt_d[c] == '0);
                full_q[c]  <= (cnt_d[c] == CNTW'(N));
            end
        end
    end

    qs_srt_mstack_spsram #(.W(W), .D(C * N), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (cmd_dat_r),
        .rdata_o (mem_rdata)
    );

    // Stage p1: read in flight inside the RAM, its context tracked alongside.
    always_ff @(posedge clk) begin
        if (rst) rd_vld_p1_q <= 1'b0;
        else     rd_vld_p1_q <= mem_re;
        if (mem_re) rd_ctx_p1_q <= cmd_ctx_r;
    end

    // Stage p2: capture RAM data into the held head register.
    always_ff @(posedge clk) begin
        if (rst) head_vld_q <= 1'b0;
        else     head_vld_q <= rd_vld_p1_q;
        if (!rst && rd_vld_p1_q) begin
            head_q     <= mem_rdata;
            head_ctx_q <= rd_ctx_p1_q;
        end
    end

    assign head_r     = head_q;
    assign head_ctx_r = head_ctx_q;
    assign head_vld_r = head_vld_q;
    assign empty_r    = empty_q;
    assign full_r     = full_q;
endmodule

// File: tb/tb_qs_srt_mstack.sv
// Testbench for qs_srt_mstack (N=4, W=8, C=2): directed scenarios followed
// by random traffic, all compared against an array-of-stacks reference.
module tb_qs_srt_mstack;
    localparam int N = 4;
    localparam int W = 8;
    localparam int C = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_vld_r;
    logic [1:0]   cmd_op_r;
    logic [0:0]   cmd_ctx_r;
    logic [W-1:0] cmd_dat_r;
    logic         cmd_err_w;
    logic [W-1:0] head_r;
    logic [0:0]   head_ctx_r;
    logic         head_vld_r;
    logic [C-1:0] empty_r;
    logic [C-1:0] full_r;

    qs_srt_mstack #(.N(N), .W(W), .C(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_vld_r  (cmd_vld_r),
        .cmd_op_r   (cmd_op_r),
        .cmd_ctx_r  (cmd_ctx_r),
        .cmd_dat_r  (cmd_dat_r),
        .cmd_err_w  (cmd_err_w),
        .head_r     (head_r),
        .head_ctx_r (head_ctx_r),
        .head_vld_r (head_vld_r),
        .empty_r    (empty_r),
        .full_r     (full_r)
    );

    always #5 clk = ~clk;

    // Reference: one array per context plus a size, and a list of due reads.
    typedef struct {
        int         due;
        int         ctx;
        logic [7:0] d;
    } rd_t;

    logic [7:0] stk [C][N];
    int         sz [C];
    rd_t        sched [$];
    int         cyc;
    int         n_tests;
    int         n_fail;
    logic       have_head;
    logic [7:0] last_head;
    logic       last_ctx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check the error flag, clock, update model, check outputs.
    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input int ctx, input logic [7:0] dat);
        logic       exp_err;
        logic [C-1:0] exp_empty, exp_full;
        rd_t        e;
        rst       = r;
        cmd_vld_r = v;
        cmd_op_r  = op;
        cmd_ctx_r = ctx[0:0];
        cmd_dat_r = dat;
        #1;
        exp_err = 1'b0;
        if (!r && v) begin
            if (op == 2'd0) exp_err = (sz[ctx] == N);
            else if (op == 2'd1 || op == 2'd2) exp_err = (sz[ctx] == 0);
        end
        chk("cmd_err", 32'(cmd_err_w), 32'(exp_err));
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int c = 0; c < C; c++) sz[c] = 0;
            sched.delete();
            have_head = 1'b0;
        end else if (v && !exp_err) begin
            case (op)
                2'd0: begin stk[ctx][sz[ctx]] = dat; sz[ctx]++; end
                2'd1: begin sz[ctx]--; sched.push_back('{cyc + 1, ctx, stk[ctx][sz[ctx]]}); end
                2'd2: sched.push_back('{cyc + 1, ctx, stk[ctx][sz[ctx] - 1]});
                default: sz[ctx] = 0;
            endcase
        end
        #1;
        if (sched.size() > 0 && sched[0].due == cyc) begin
            e = sched.pop_front();
            chk("head_vld", 32'(head_vld_r), 32'd1);
            chk("head_dat", 32'(head_r), 32'(e.d));
            chk("head_ctx", 32'(head_ctx_r), 32'(e.ctx));
            have_head = 1'b1;
            last_head = e.d;
            last_ctx  = e.ctx[0];
        end else begin
            chk("head_vld", 32'(head_vld_r), 32'd0);
            if (have_head) begin
                chk("head_hold", 32'(head_r), 32'(last_head));
                chk("ctx_hold", 32'(head_ctx_r), 32'(last_ctx));
            end
        end
        for (int c = 0; c < C; c++) begin
            exp_empty[c] = (sz[c] == 0);
            exp_full[c]  = (sz[c] == N);
        end
        chk("empty", 32'(empty_r), 32'(exp_empty));
        chk("full", 32'(full_r), 32'(exp_full));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 0, 8'h00);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        have_head = 1'b0;
        last_head = '0;
        last_ctx  = 1'b0;
        for (int c = 0; c < C; c++) sz[c] = 0;
        rst = 1'b1; cmd_vld_r = 1'b0; cmd_op_r = '0; cmd_ctx_r = '0; cmd_dat_r = '0;

        // Reset, including a command presented during reset that must be ignored.
        step(1'b1, 1'b0, 2'd0, 0, 8'h00);
        step(1'b1, 1'b1, 2'd0, 0, 8'hEE);
        chk("rst_empty", 32'(empty_r), 32'h3);
        chk("rst_full", 32'(full_r), 32'h0);

        // Fill ctx0, overflow, drain in LIFO order.
        step(1'b0, 1'b1, 2'd0, 0, 8'h11);
        step(1'b0, 1'b1, 2'd0, 0, 8'h22);
        step(1'b0, 1'b1, 2'd0, 0, 8'h33);
        step(1'b0, 1'b1, 2'd0, 0, 8'h44);
        chk("full_ctx0", 32'(full_r), 32'h1);
        step(1'b0, 1'b1, 2'd0, 0, 8'h55);
        chk("full_after_ovf", 32'(full_r), 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd1, 0, 8'h00);
        idle(2);
        chk("drained", 32'(empty_r), 32'h3);

        // Empty POP rejected; PEEK after PUSH.
        step(1'b0, 1'b1, 2'd1, 1, 8'h00);
        step(1'b0, 1'b1, 2'd0, 0, 8'hA5);
        step(1'b0, 1'b1, 2'd2, 0, 8'h00);
        idle(2);
        chk("peek_head", 32'(head_r), 32'hA5);
        step(1'b0, 1'b1, 2'd3, 0, 8'h00);

        // Interleaved contexts, back-to-back heads.
        step(1'b0, 1'b1, 2'd0, 0, 8'h01);
        step(1'b0, 1'b1, 2'd0, 1, 8'h02);
        step(1'b0, 1'b1, 2'd1, 0, 8'h00);
        step(1'b0, 1'b1, 2'd1, 1, 8'h00);
        idle(2);

        // POP then CLR/PUSH on the same context: issued read still delivered intact.
        step(1'b0, 1'b1, 2'd0, 0, 8'h77);
        step(1'b0, 1'b1, 2'd0, 0, 8'h88);
        step(1'b0, 1'b1, 2'd1, 0, 8'h00);
        step(1'b0, 1'b1, 2'd0, 0, 8'h99);
        step(1'b0, 1'b1, 2'd1, 0, 8'h00);
        step(1'b0, 1'b1, 2'd3, 0, 8'h00);
        idle(2);

        // POP then reset: in-flight read dropped.
        step(1'b0, 1'b1, 2'd0, 1, 8'h3C);
        step(1'b0, 1'b1, 2'd1, 1, 8'h00);
        step(1'b1, 1'b0, 2'd0, 0, 8'h00);
        idle(2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0),
                 2'(($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, 3)),
                 int'($urandom_range(0, C - 1)), 8'($urandom));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
